cp0_unit: RTL
=============

Name: cp0_unit

Overview:
- Coprocessor-0 for the 5-stage MIPS pipeline. It is the consuming end of the exception fields carried down the pipeline registers to the M stage (exception code, branch-delay flag, victim PC), plus the six external hardware interrupt lines.
- It arbitrates interrupt against exception, latches SR/Cause/EPC, and serves mfc0/mtc0/eret.
- Its Req output flushes all pipeline registers and redirects fetch to the handler. EPCOut feeds the eret redirect.

Parameters:
- PRID, 32'h2023_0007, read-only processor ID returned at CP0 register 15.
- HANDLER_EN, 1, when 0 Req is forced low (bring-up/debug builds); registers still update from mtc0.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  reset, asynchronous, active-low.
- en  in  1  mtc0 write enable (M-stage mtc0).
- CP0_addr  in  5  CP0 register number for mfc0/mtc0.
- CP0_in  in  32  mtc0 write data (M-stage RT value).
- CP0_out  out  32  mfc0 read data, combinational.
- VPC  in  32  victim PC (M-stage instruction PC).
- BDIn  in  1  M-stage instruction sits in a branch delay slot.
- ExcCodeIn  in  5  M-stage exception code; 0 means no exception.
- HWInt  in  6  external interrupt lines, level-sensitive.
- EXLClr  in  1  eret in M stage.
- EPCOut  out  32  current EPC register.
- Req  out  1  take exception/interrupt this cycle, combinational.

Behaviour:
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): 32 bits.
  - PRId(15): returns PRID.
  - Any other address reads 0, and writes to it are ignored.
- Reset (res=0, async): IM=0, EXL=0, IE=0, BD=0, IP=0, ExcCode=0, EPC=0. Therefore EPCOut=0, CP0_out=0 for addr 12/13/14, and Req=0.
- Request logic (combinational):
  - IntReq = IE & ~EXL & |(HWInt & IM).
  - ExcReq = ~EXL & (ExcCodeIn != 0).
  - Req = HANDLER_EN & (IntReq | ExcReq).
- Priority: interrupt over exception. When IntReq=1, the logged ExcCode is 0 regardless of ExcCodeIn.
- On a rising edge with Req=1:
  - EXL <= 1.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - BD <= BDIn.
  - EPC <= BDIn ? VPC-4 : VPC, computed modulo 2^32 (VPC=0 with BDIn=1 wraps to 32'hFFFF_FFFC).
- IP[15:10] <= HWInt on every edge, regardless of Req or EXL. This gives one cycle of latency to the Cause read.
- mtc0 (en=1, Req=0): writes the addressed register. SR takes IM/EXL/IE from CP0_in; EPC takes CP0_in[31:0]; Cause and PRId are read-only.
- en=1 with Req=1: the write is suppressed (the flushed mtc0 must not commit).
- EXLClr=1 with Req=0: EXL <= 0 at the edge.
- EXLClr=1 with Req=1: Req wins, and EXL stays 1.
- EXLClr and an mtc0 to SR in the same cycle: EXLClr overrides the EXL bit; IM/IE take CP0_in.
- Reads: CP0_out reflects register state before the edge. A same-cycle mtc0 is not forwarded.
- While EXL=1 all requests are masked. Nested exceptions are unsupported by design.
- Reset asserted mid-operation: all state clears immediately and Req drops without waiting for a clock edge.

Decomposition:
- Shared package holds:
  - CP0 register numbers: SR=12, CAUSE=13, EPC=14, PRID=15.
  - Bit-field positions: IM, EXL, IE, BD, IP, ExcCode.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
- One sub-module, cp0_req_arb: the combinational IntReq/ExcReq/priority/next-ExcCode logic, kept separate for standalone formal checking. Register file and read mux stay in cp0_unit.

Test Plan:
1. Reset checks: hold res=0 with HWInt=6'h3F -> Req=0, EPCOut=0, CP0_out=0 at addr 12/13/14; release res -> still Req=0 (IE=0).
2. Interrupt entry: mtc0 SR=32'h0000_FC01, then HWInt=6'b000100 with VPC=32'h0000_3010 and BDIn=0 -> Req=1 same cycle. Next cycle: EPC=32'h0000_3010, Cause=32'h0000_1000, SR reads 32'h0000_FC03, Req=0.
3. Exception in delay slot: ExcCodeIn=12, BDIn=1, VPC=32'h0000_3404 -> EPC=32'h0000_3400, Cause=32'h8000_0030.
4. Priority: ExcCodeIn=4 and an enabled interrupt in the same cycle -> ExcCode logged 0, one Req pulse only.
5. Write suppression and eret: en=1 with addr 14, CP0_in=32'h1234_5678, together with a pending exception -> EPC takes the VPC value, not CP0_in. Then EXLClr=1 -> SR EXL bit clears next cycle and pending HWInt raises Req again.
6. Async reset mid-operation: assert res low between clock edges while EXL=1 and EPC is nonzero -> SR/Cause/EPC read 0 immediately.

Source files
------------

// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes.
// Also holds the EPC-from-victim-PC helper used when an exception is taken.
package cp0_unit_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int IP_HI   = 15;
    localparam int IP_LO   = 10;
    localparam int EXC_HI  = 6;
    localparam int EXC_LO  = 2;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // A delay-slot victim restarts at the branch, one word earlier (wraps mod 2^32).
    function automatic logic [31:0] victim_epc(input logic [31:0] vpc, input logic bd);
        return bd ? (vpc - 32'd4) : vpc;
    endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// Pipeline-side CP0 signal bundle: M-stage exception fields, mtc0/mfc0, eret, outputs.
interface cp0_unit_if;
    logic        en;
    logic [4:0]  CP0_addr;
    logic [31:0] CP0_in;
    logic [31:0] CP0_out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    modport master (
        output en, CP0_addr, CP0_in, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  CP0_out, EPCOut, Req
    );

    modport slave (
        input  en, CP0_addr, CP0_in, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output CP0_out, EPCOut, Req
    );
endinterface

// File: rtl/cp0_req_arb.sv
// Combinational interrupt/exception arbitration for CP0.
// Interrupts win over exceptions; an interrupt logs ExcCode 0.
module cp0_req_arb
    import cp0_unit_pkg::*;
#(
    parameter bit HANDLER_EN = 1'b1
) (
    input  logic       ie,
    input  logic       exl,
    input  logic [5:0] im,
    input  logic [5:0] hw_int,
    input  logic [4:0] exc_code_in,
    output logic       req,
    output logic [4:0] exc_code_nxt
);

    logic int_req;
    logic exc_req;

    assign int_req      = ie & ~exl & (|(hw_int & im));
    assign exc_req      = ~exl & (exc_code_in != 5'd0);
    assign req          = HANDLER_EN & (int_req | exc_req);
    assign exc_code_nxt = int_req ? 5'(EXC_INT) : exc_code_in;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId register file, exception entry, mtc0/mfc0, eret.
// Req flushes the pipeline and redirects fetch; EPCOut feeds the eret redirect.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID       = 32'h2023_0007,
    parameter bit          HANDLER_EN = 1'b1
) (
    input  logic      clk,
    input  logic      res,
    cp0_unit_if.slave cp0
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic        req;
    logic [4:0]  exc_code_nxt;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] rd_data;

    cp0_req_arb #(.HANDLER_EN(HANDLER_EN)) u_arb (
        .ie           (ie_q),
        .exl          (exl_q),
        .im           (im_q),
        .hw_int       (cp0.HWInt),
        .exc_code_in  (cp0.ExcCodeIn),
        .req          (req),
        .exc_code_nxt (exc_code_nxt)
    );

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        ip_d       = cp0.HWInt;

        if (req) begin
            // Flushed mtc0/eret in the same cycle must not commit.
            exl_d      = 1'b1;
            exc_code_d = exc_code_nxt;
            bd_d       = cp0.BDIn;
            epc_d      = victim_epc(cp0.VPC, cp0.BDIn);
        end else begin
            if (cp0.en) begin
                case (cp0.CP0_addr)
                    REG_SR: begin
                        im_d  = cp0.CP0_in[IM_HI:IM_LO];
                        exl_d = cp0.CP0_in[EXL_BIT];
                        ie_d  = cp0.CP0_in[IE_BIT];
                    end
                    REG_EPC: epc_d = cp0.CP0_in;
                    default: ;
                endcase
            end
            if (cp0.EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        sr_word                  = '0;
        sr_word[IM_HI:IM_LO]     = im_q;
        sr_word[EXL_BIT]         = exl_q;
        sr_word[IE_BIT]          = ie_q;

        cause_word               = '0;
        cause_word[BD_BIT]       = bd_q;
        cause_word[IP_HI:IP_LO]  = ip_q;
        cause_word[EXC_HI:EXC_LO] = exc_code_q;

        rd_data = '0;
        case (cp0.CP0_addr)
            REG_SR:    rd_data = sr_word;
            REG_CAUSE: rd_data = cause_word;
            REG_EPC:   rd_data = epc_q;
            REG_PRID:  rd_data = PRID;
            default:   rd_data = '0;
        endcase
    end

    assign cp0.CP0_out = rd_data;
    assign cp0.EPCOut  = epc_q;
    assign cp0.Req     = req;

endmodule
